// File: rtl/axi_pkg.sv
// Shared AXI encodings and the burst-master state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int BEAT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WDATA = 3'd4,
    ST_WRESP = 3'd5
  } mst_state_e;

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the R and W data phases; is_last flags the final beat.
module axi_beat_counter
  import axi_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              incr,
  input  logic [BEAT_W-1:0] len,
  output logic [BEAT_W-1:0] count,
  output logic              is_last
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= count + 1'b1;
    end
  end

  assign is_last = (count == len);

endmodule

// File: rtl/axi_burst_master.sv
// AXI-style burst initiator: one read or write burst at a time, done/err on completion.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [7:0]          req_len,
  input  logic [2:0]          req_size,
  input  logic                usr_wvalid,
  output logic                usr_wready,
  input  logic [DATA_W-1:0]   usr_wdata,
  input  logic [DATA_W/8-1:0] usr_wstrb,
  output logic                usr_rvalid,
  input  logic                usr_rready,
  output logic [DATA_W-1:0]   usr_rdata,
  output logic                usr_rlast,
  output logic                done,
  output logic                err,
  output logic                io_Sram_ar_valid,
  input  logic                io_Sram_ar_ready,
  output logic [ADDR_W-1:0]   io_Sram_ar_bits_addr,
  output logic [7:0]          io_ar_len,
  output logic [2:0]          io_ar_size,
  output logic [1:0]          io_ar_burst,
  input  logic                io_Sram_r_valid,
  output logic                io_Sram_r_ready,
  input  logic [DATA_W-1:0]   io_Sram_r_bits_data,
  input  logic [1:0]          io_Sram_r_rresp,
  input  logic                io_Sram_r_bits_last,
  output logic                io_Sram_aw_valid,
  input  logic                io_Sram_aw_ready,
  output logic [ADDR_W-1:0]   io_Sram_aw_bits_addr,
  output logic [7:0]          io_aw_len,
  output logic [2:0]          io_aw_size,
  output logic [1:0]          io_aw_burst,
  output logic                io_Sram_w_valid,
  input  logic                io_Sram_w_ready,
  output logic [DATA_W-1:0]   io_Sram_w_bits_data,
  output logic [DATA_W/8-1:0] io_Sram_w_bits_strb,
  output logic                io_Sram_w_bits_last,
  input  logic                io_b_valid,
  output logic                io_b_ready,
  input  logic [1:0]          io_b_bresp,
  output logic [2:0]          dbg_state,
  output logic [7:0]          dbg_beat
);

  mst_state_e state, state_nx;

  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_len;
  logic [2:0]        lat_size;
  logic              err_acc;
  logic              done_q;
  logic              err_q;

  logic [7:0] beat_cnt;
  logic       is_last;

  // A transfer happens on any cycle where valid and ready are both high;
  // valid never waits on ready, and payload is held stable while valid is up.
  logic accept, r_hs, w_hs, b_hs, r_beat_err, b_err, final_hs, acc_next;

  assign accept     = (state == ST_IDLE)  && req_valid;
  assign r_hs       = (state == ST_RDATA) && io_Sram_r_valid && usr_rready;
  assign w_hs       = (state == ST_WDATA) && usr_wvalid && io_Sram_w_ready;
  assign b_hs       = (state == ST_WRESP) && io_b_valid;
  assign r_beat_err = (io_Sram_r_rresp != RESP_OKAY) || (io_Sram_r_bits_last != is_last);
  assign b_err      = (io_b_bresp != RESP_OKAY);
  assign final_hs   = (r_hs && is_last) || b_hs;
  assign acc_next   = err_acc || (r_hs && r_beat_err) || (b_hs && b_err);

  // The counter holds at len on the final beat so len=255 never wraps.
  axi_beat_counter u_beat_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .incr    ((r_hs || w_hs) && !is_last),
    .len     (lat_len),
    .count   (beat_cnt),
    .is_last (is_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nx = req_write ? ST_WADDR : ST_RADDR;
      ST_RADDR: if (io_Sram_ar_ready) state_nx = ST_RDATA;
      ST_RDATA: if (r_hs && is_last) state_nx = ST_IDLE;
      ST_WADDR: if (io_Sram_aw_ready) state_nx = ST_WDATA;
      ST_WDATA: if (w_hs && is_last) state_nx = ST_WRESP;
      ST_WRESP: if (io_b_valid) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_addr <= '0;
      lat_len  <= '0;
      lat_size <= '0;
      err_acc  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr <= req_addr;
        lat_len  <= req_len;
        lat_size <= req_size;
        err_acc  <= 1'b0;
      end else begin
        err_acc  <= acc_next;
      end
      done_q <= final_hs;
      err_q  <= final_hs && acc_next;
    end
  end

  always_comb begin
    req_ready           = 1'b0;
    usr_wready          = 1'b0;
    usr_rvalid          = 1'b0;
    usr_rdata           = '0;
    usr_rlast           = 1'b0;
    io_Sram_ar_valid    = 1'b0;
    io_Sram_r_ready     = 1'b0;
    io_Sram_aw_valid    = 1'b0;
    io_Sram_w_valid     = 1'b0;
    io_Sram_w_bits_data = '0;
    io_Sram_w_bits_strb = '0;
    io_Sram_w_bits_last = 1'b0;
    io_b_ready          = 1'b0;
    case (state)
      ST_IDLE:  req_ready = reset;
      ST_RADDR: io_Sram_ar_valid = 1'b1;
      ST_RDATA: begin
        usr_rvalid      = io_Sram_r_valid;
        io_Sram_r_ready = usr_rready;
        usr_rdata       = io_Sram_r_bits_data;
        usr_rlast       = is_last;
      end
      ST_WADDR: io_Sram_aw_valid = 1'b1;
      ST_WDATA: begin
        io_Sram_w_valid     = usr_wvalid;
        usr_wready          = io_Sram_w_ready;
        io_Sram_w_bits_data = usr_wdata;
        io_Sram_w_bits_strb = usr_wstrb;
        io_Sram_w_bits_last = is_last;
      end
      ST_WRESP: io_b_ready = 1'b1;
      default: ;
    endcase
  end

  assign io_Sram_ar_bits_addr = lat_addr;
  assign io_ar_len            = lat_len;
  assign io_ar_size           = lat_size;
  assign io_ar_burst          = BURST_INCR;
  assign io_Sram_aw_bits_addr = lat_addr;
  assign io_aw_len            = lat_len;
  assign io_aw_size           = lat_size;
  assign io_aw_burst          = BURST_INCR;

  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state;
  assign dbg_beat  = beat_cnt;

endmodule
